// File: rtl/vec_mem_seq_pkg.sv
// Shared types and constants for the vec_mem_seq vector load/store sequencer.
package vec_mem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } vms_state_e;

  localparam logic OP_VLD = 1'b0;
  localparam logic OP_VST = 1'b1;

  localparam int unsigned OFFW = 6;

endpackage

// File: rtl/vms_agen.sv
// Element address generator: loads base+offset, then steps by the latched stride
// (VMS_STRIDE_EN defined) or by a fixed unit increment; all arithmetic wraps mod 2^AW.
module vms_agen
  import vec_mem_seq_pkg::*;
#(
  parameter int unsigned AW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [AW-1:0]   base,
  input  logic [OFFW-1:0] offset,
  input  logic [AW-1:0]   stride,
  output logic [AW-1:0]   addr_q,
  output logic [AW-1:0]   addr_d
);

  logic [AW-1:0] inc;

`ifdef VMS_STRIDE_EN
  logic [AW-1:0] inc_q;
  logic [AW-1:0] inc_d;

  always_comb begin
    inc_d = inc_q;
    if (load) inc_d = stride;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inc_q <= '0;
    else     inc_q <= inc_d;
  end

  assign inc = inc_q;
`else
  logic stride_unused;
  assign stride_unused = ^stride;
  assign inc           = AW'(1);
`endif

  always_comb begin
    addr_d = addr_q;
    if (load)      addr_d = base + AW'(offset);
    else if (step) addr_d = addr_q + inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) addr_q <= '0;
    else     addr_q <= addr_d;
  end

endmodule

// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer between a vector register file and memory.
// Build option: define VMS_STRIDE_EN to honour the stride port (otherwise unit stride).
module vec_mem_seq
  import vec_mem_seq_pkg::*;
#(
  parameter int unsigned DW   = 16,
  parameter int unsigned AW   = 16,
  parameter int unsigned VLEN = 16,
  parameter int unsigned IW   = $clog2(VLEN)
) (
  input  logic            Clk1,
  input  logic            Reset,
  input  logic            start,
  input  logic            op,
  input  logic [AW-1:0]   base,
  input  logic [OFFW-1:0] offset,
  input  logic [AW-1:0]   stride,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   Addr,
  output logic            RD,
  output logic            WR,
  output logic [DW-1:0]   DataOut,
  input  logic [DW-1:0]   DataIn,
  output logic [IW-1:0]   vIdx,
  output logic            vWr,
  output logic [DW-1:0]   vWrData,
  input  logic [DW-1:0]   vRdData
);

  localparam int unsigned CW   = (VLEN > 1) ? $clog2(VLEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(VLEN - 1);

  vms_state_e    state_q, state_d;
  logic          op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          done_q, done_d;
  logic [AW-1:0] addr_out_q, addr_out_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          vwr_q, vwr_d;
  logic [CW-1:0] widx_q, widx_d;

  logic          agen_load;
  logic          agen_step;
  logic [AW-1:0] agen_addr_q;
  logic [AW-1:0] agen_addr_d;

  vms_agen #(
    .AW(AW)
  ) u_agen (
    .clk    (Clk1),
    .rst    (Reset),
    .load   (agen_load),
    .step   (agen_step),
    .base   (base),
    .offset (offset),
    .stride (stride),
    .addr_q (agen_addr_q),
    .addr_d (agen_addr_d)
  );

  // Outputs are registered one step ahead: a load's RD/Addr is set on the edge that
  // enters (or stays in) STREAM, so RD for element k is visible while cnt_q == k.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    done_d     = 1'b0;
    addr_out_d = addr_out_q;
    dout_d     = dout_q;
    vwr_d      = rd_q;
    widx_d     = rd_q ? cnt_q : '0;
    agen_load  = 1'b0;
    agen_step  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = STREAM;
          op_d      = op;
          cnt_d     = '0;
          agen_load = 1'b1;
          if (op == OP_VLD) begin
            rd_d       = 1'b1;
            addr_out_d = agen_addr_d;
          end
        end
      end
      STREAM: begin
        agen_step = 1'b1;
        if (op_q == OP_VLD) begin
          if (cnt_q != LAST) begin
            rd_d       = 1'b1;
            addr_out_d = agen_addr_d;
          end
        end else begin
          wr_d       = 1'b1;
          addr_out_d = agen_addr_q;
          dout_d     = vRdData;
        end
        if (cnt_q == LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk1 or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      op_q       <= OP_VLD;
      cnt_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
      addr_out_q <= '0;
      dout_q     <= '0;
      vwr_q      <= 1'b0;
      widx_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      done_q     <= done_d;
      addr_out_q <= addr_out_d;
      dout_q     <= dout_d;
      vwr_q      <= vwr_d;
      widx_q     <= widx_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign Addr    = addr_out_q;
  assign RD      = rd_q;
  assign WR      = wr_q;
  assign DataOut = dout_q;
  assign vWr     = vwr_q;
  // Store streams the register index from the element counter; loads index the write-back.
  assign vIdx    = (state_q == STREAM && op_q == OP_VST) ? IW'(cnt_q) : IW'(widx_q);
  assign vWrData = vwr_q ? DataIn : '0;

endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed bench for vec_mem_seq: VLEN=4 instance plus a VLEN=1 instance.
module tb_vec_mem_seq;

  logic Clk1  = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk1 = ~Clk1;

  logic        start, op;
  logic [15:0] base, stride;
  logic [5:0]  offset;
  logic        busy, done, RD, WR, vWr;
  logic [15:0] Addr, DataOut, vWrData, vRdData;
  logic [15:0] DataIn = '0;
  logic [1:0]  vIdx;

  logic        start1, op1;
  logic [15:0] base1, stride1;
  logic [5:0]  offset1;
  logic        busy1, done1, RD1, WR1, vWr1;
  logic [15:0] Addr1, DataOut1, vWrData1, vRdData1;
  logic [15:0] DataIn1 = '0;
  logic [0:0]  vIdx1;

  int checks = 0;
  int errors = 0;

  logic [15:0] ld_addr [4];
  logic [15:0] st_addr [4];
  logic [15:0] vregs   [4];

  vec_mem_seq #(.DW(16), .AW(16), .VLEN(4)) u_dut (
    .Clk1(Clk1), .Reset(Reset), .start(start), .op(op), .base(base), .offset(offset),
    .stride(stride), .busy(busy), .done(done), .Addr(Addr), .RD(RD), .WR(WR),
    .DataOut(DataOut), .DataIn(DataIn), .vIdx(vIdx), .vWr(vWr), .vWrData(vWrData),
    .vRdData(vRdData)
  );

  vec_mem_seq #(.DW(16), .AW(16), .VLEN(1), .IW(1)) u_dut1 (
    .Clk1(Clk1), .Reset(Reset), .start(start1), .op(op1), .base(base1), .offset(offset1),
    .stride(stride1), .busy(busy1), .done(done1), .Addr(Addr1), .RD(RD1), .WR(WR1),
    .DataOut(DataOut1), .DataIn(DataIn1), .vIdx(vIdx1), .vWr(vWr1), .vWrData(vWrData1),
    .vRdData(vRdData1)
  );

  // Memory returns Addr ^ 16'hA55A the cycle after RD.
  always @(posedge Clk1) if (RD) DataIn <= Addr ^ 16'hA55A;
  assign vRdData  = vregs[vIdx];
  assign vRdData1 = (vIdx1 == 1'b0) ? 16'hBEEF : 16'h0000;

  task automatic test_reset();
    #1 Reset = 1'b1;
    @(negedge Clk1);
    checks++;
    if ({busy, done, RD, WR, vWr, Addr, DataOut, vIdx, vWrData} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b rd=%b wr=%b vwr=%b addr=%h dout=%h vidx=%h exp all 0",
               busy, done, RD, WR, vWr, Addr, DataOut, vIdx);
    end
    checks++;
    if ({busy1, done1, RD1, WR1, vWr1, Addr1, DataOut1, vIdx1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_v1 got busy=%b done=%b wr=%b addr=%h exp all 0", busy1, done1, WR1, Addr1);
    end
    @(negedge Clk1);
    Reset = 1'b0;
  endtask

  task automatic test_load();
    logic exp_rd, exp_vwr;
    base = 16'h0100; offset = 6'd3; stride = 16'd2; op = 1'b0; start = 1'b1;
    @(posedge Clk1);
    #1 start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge Clk1);
      exp_rd  = (c >= 1 && c <= 4);
      exp_vwr = (c >= 2 && c <= 5);
      checks++;
      if (RD !== exp_rd) begin errors++; $display("FAIL load_rd c=%0d got %b exp %b", c, RD, exp_rd); end
      if (exp_rd) begin
        checks++;
        if (Addr !== ld_addr[c-1]) begin errors++; $display("FAIL load_addr c=%0d got %h exp %h", c, Addr, ld_addr[c-1]); end
      end
      checks++;
      if (vWr !== exp_vwr) begin errors++; $display("FAIL load_vwr c=%0d got %b exp %b", c, vWr, exp_vwr); end
      if (exp_vwr) begin
        checks++;
        if (vIdx !== 2'(c-2)) begin errors++; $display("FAIL load_vidx c=%0d got %0d exp %0d", c, vIdx, c-2); end
        checks++;
        if (vWrData !== (ld_addr[c-2] ^ 16'hA55A)) begin
          errors++; $display("FAIL load_vwrdata c=%0d got %h exp %h", c, vWrData, ld_addr[c-2] ^ 16'hA55A);
        end
      end
      checks++;
      if (done !== (c == 6)) begin errors++; $display("FAIL load_done c=%0d got %b exp %b", c, done, c == 6); end
      checks++;
      if (busy !== (c <= 6)) begin errors++; $display("FAIL load_busy c=%0d got %b exp %b", c, busy, c <= 6); end
      checks++;
      if (WR !== 1'b0) begin errors++; $display("FAIL load_wr c=%0d got %b exp 0", c, WR); end
    end
  endtask

  task automatic test_store();
    logic exp_wr;
    base = 16'hFFFE; offset = 6'd0; stride = 16'd1; op = 1'b1; start = 1'b1;
    @(posedge Clk1);
    #1 start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge Clk1);
      exp_wr = (c >= 2 && c <= 5);
      checks++;
      if (WR !== exp_wr) begin errors++; $display("FAIL store_wr c=%0d got %b exp %b", c, WR, exp_wr); end
      if (exp_wr) begin
        checks++;
        if (Addr !== st_addr[c-2]) begin errors++; $display("FAIL store_addr c=%0d got %h exp %h", c, Addr, st_addr[c-2]); end
        checks++;
        if (DataOut !== vregs[c-2]) begin errors++; $display("FAIL store_data c=%0d got %h exp %h", c, DataOut, vregs[c-2]); end
      end
      checks++;
      if ({RD, vWr} !== 2'b00) begin errors++; $display("FAIL store_rd_vwr c=%0d got rd=%b vwr=%b exp 0", c, RD, vWr); end
      checks++;
      if (done !== (c == 6)) begin errors++; $display("FAIL store_done c=%0d got %b exp %b", c, done, c == 6); end
      checks++;
      if (busy !== (c <= 6)) begin errors++; $display("FAIL store_busy c=%0d got %b exp %b", c, busy, c <= 6); end
    end
  endtask

  task automatic test_back_to_back();
    int  dones = 0;
    bit  seen  = 0;
    base = 16'h0100; offset = 6'd3; stride = 16'd2; op = 1'b0; start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge Clk1);
      if (done) dones++;
      if (c <= 4) begin
        checks++;
        if (Addr !== ld_addr[c-1]) begin errors++; $display("FAIL b2b_addr c=%0d got %h exp %h", c, Addr, ld_addr[c-1]); end
      end
    end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL b2b_done_count got %0d exp 1", dones); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_c7 got busy=%b exp 0", busy); end
    @(negedge Clk1);
    start = 1'b0;
    checks++;
    if ({busy, RD, Addr} !== {1'b1, 1'b1, ld_addr[0]}) begin
      errors++; $display("FAIL b2b_restart_c8 got busy=%b rd=%b addr=%h exp 1 1 %h", busy, RD, Addr, ld_addr[0]);
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clk1);
      if (done) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL b2b_second_done got none within 20 cycles exp 1 pulse"); end
    @(negedge Clk1);
  endtask

  task automatic test_reset_mid();
    base = 16'h0100; offset = 6'd3; stride = 16'd2; op = 1'b0; start = 1'b1;
    @(posedge Clk1);
    #1 start = 1'b0;
    @(posedge Clk1);
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, RD, WR, vWr, Addr, DataOut, vIdx, vWrData} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got busy=%b done=%b rd=%b vwr=%b addr=%h vidx=%h exp all 0",
               busy, done, RD, vWr, Addr, vIdx);
    end
    @(negedge Clk1);
    Reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk1);
      checks++;
      if ({busy, done, RD, vWr} !== 4'b0000) begin
        errors++; $display("FAIL midreset_quiet c=%0d got busy=%b done=%b rd=%b vwr=%b exp 0", c, busy, done, RD, vWr);
      end
    end
  endtask

  task automatic test_vlen1();
    base1 = 16'h0040; offset1 = 6'd0; stride1 = 16'd1; op1 = 1'b1; start1 = 1'b1;
    @(posedge Clk1);
    #1 start1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clk1);
      checks++;
      if (WR1 !== (c == 2)) begin errors++; $display("FAIL v1_wr c=%0d got %b exp %b", c, WR1, c == 2); end
      if (c == 2) begin
        checks++;
        if ({Addr1, DataOut1} !== {16'h0040, 16'hBEEF}) begin
          errors++; $display("FAIL v1_addr_data got %h/%h exp 0040/beef", Addr1, DataOut1);
        end
      end
      checks++;
      if (done1 !== (c == 3)) begin errors++; $display("FAIL v1_done c=%0d got %b exp %b", c, done1, c == 3); end
      checks++;
      if (busy1 !== (c <= 3)) begin errors++; $display("FAIL v1_busy c=%0d got %b exp %b", c, busy1, c <= 3); end
      checks++;
      if (RD1 !== 1'b0) begin errors++; $display("FAIL v1_rd c=%0d got %b exp 0", c, RD1); end
    end
  endtask

  initial begin
`ifdef VMS_STRIDE_EN
    ld_addr = '{16'h0103, 16'h0105, 16'h0107, 16'h0109};
`else
    ld_addr = '{16'h0103, 16'h0104, 16'h0105, 16'h0106};
`endif
    st_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    vregs   = '{16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3};
    start  = 1'b0; op  = 1'b0; base  = '0; offset  = '0; stride  = '0;
    start1 = 1'b0; op1 = 1'b0; base1 = '0; offset1 = '0; stride1 = '0;

    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_reset_mid();
    test_store();
    test_vlen1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_mem_seq.md
VEC_MEM_SEQ -- requirements
Module: vec_mem_seq

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DW, 16, data/element width
- AW, 16, memory address width
- VLEN, 16, elements per vector transfer
- IW, $clog2(VLEN), element index width
REQ-002 Ports (name, direction, width, meaning), one per line:
- Clk1, in, 1, single clock, rising edge
- Reset, in, 1, asynchronous active-high reset
- start, in, 1, request a transfer
- op, in, 1, 0 = vector load (mem->reg), 1 = vector store (reg->mem)
- base, in, AW, base address
- offset, in, 6, unsigned offset added to base
- stride, in, AW, element address increment
- busy, out, 1, transfer in progress
- done, out, 1, one-cycle completion pulse
- Addr, out, AW, memory address
- RD, out, 1, memory read strobe
- WR, out, 1, memory write strobe
- DataOut, out, DW, memory write data
- DataIn, in, DW, memory read data, valid the cycle after RD
- vIdx, out, IW, vector register element index
- vWr, out, 1, element write strobe
- vWrData, out, DW, element write data
- vRdData, in, DW, element read data, combinational from vIdx
REQ-003 Clock and reset are fixed: one clock (Clk1); Reset is asynchronous and active-high.

Function
REQ-004 Implement the FSM states IDLE, STREAM, DRAIN and DONE; busy=1 in every state except IDLE.
REQ-005 Accept start only in IDLE: latch op and stride, set addr=base+offset (offset zero-extended), set cnt=0, go to STREAM; ignore start in all other states.
REQ-006 Load, STREAM: each cycle assert RD=1 with Addr=addr; increment cnt; advance addr by stride; after element VLEN-1 go to DRAIN.
REQ-007 Load write-back: use a registered flag/index pipe so vWr=1 and vIdx=k in the cycle after the RD for element k, with vWrData=DataIn (pass-through); the last write-back occurs in DRAIN.
REQ-008 Store, STREAM: each cycle drive vIdx=cnt, register DataOut<=vRdData and Addr<=addr, and assert WR=1 in the following cycle; after element VLEN-1 go to DRAIN, which completes the final WR.
REQ-009 DRAIN: RD=0 and next state is DONE. DONE: done=1 for exactly one cycle, WR=RD=vWr=0, next state is IDLE.
REQ-010 Latency: the start edge is cycle 0; done is high in cycle VLEN+2 for both ops; a new start is accepted in cycle VLEN+3 at the earliest.
REQ-011 Address arithmetic is modulo 2^AW, so wrap-around past the top of memory is silent.
REQ-012 RD and WR are never high in the same cycle; vWr is never high during a store.
REQ-013 start asserted together with done is ignored.
REQ-014 VLEN=1 is legal: one element, same state sequence.

Reset
REQ-015 Reset asserted at any time, including mid-transfer: go immediately to IDLE; busy, done, RD, WR and vWr=0; Addr, DataOut and vIdx=0; cnt and the pipe are cleared; no partial completion pulse.
REQ-016 First start is accepted on the first rising Clk1 edge after Reset deasserts.

Configuration
REQ-017 Macro VMS_STRIDE_EN defined: the stride port is honoured as in REQ-006.
REQ-018 Macro VMS_STRIDE_EN undefined: stride is ignored and the increment is fixed at 1; the port remains present and unused.

Structure
REQ-019 A shared package holds the state enum (IDLE/STREAM/DRAIN/DONE), the op encodings (OP_VLD=0, OP_VST=1) and the offset width constant (6).
REQ-020 One sub-module, vms_agen, contains the address generator (base+offset load, stride/unit increment, wrap); everything else is in vec_mem_seq.

Verification
REQ-021 Load, VLEN=4, base=0x0100, offset=3, stride=2 (macro on) -> RD at Addr 0x0103, 0x0105, 0x0107, 0x0109 in cycles 1-4; vWr idx 0-3 carries the memory data in cycles 2-5; done in cycle 6.
REQ-022 Same load with macro off -> Addr 0x0103, 0x0104, 0x0105, 0x0106.
REQ-023 Store, VLEN=4, base=0xFFFE, offset=0, stride=1, register data A0..A3 -> WR at Addr 0xFFFE, 0xFFFF, 0x0000, 0x0001 with DataOut A0..A3; RD=0 throughout.
REQ-024 Second start in cycles 1..VLEN+2 of an active transfer -> ignored; only one done pulse; the next start is accepted in cycle VLEN+3.
REQ-025 Reset pulsed in cycle 2 of a load -> all outputs 0 within the same cycle; no done pulse; a following store runs normally.
REQ-026 VLEN=1 store of 0xBEEF to 0x0040 -> one WR in cycle 2; done in cycle 3.
